sqrt_controller: RTL

- Control FSM and remainder datapath for the odd-number-subtraction integer square root. Sits directly around the odd-integer register `square_root`.
- Consumes that register's `curr_num` and drives its `Inc` and reset.
- Repeatedly subtracts successive odd integers (1, 3, 5, …) from a latched operand. The number of successful subtractions is floor(sqrt(N)); the residue is N − root².

---
 rtl/sqrt_pkg.sv | 14 +
 rtl/sqrt_controller_if.sv | 14 +
 rtl/sqrt_top.sv | 33 +++
 rtl/square_root.sv | 27 ++
 rtl/sqrt_controller.sv | 105 ++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared types for the odd-subtraction square-root controller.
package sqrt_pkg;

  localparam int unsigned SQRT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CMP  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sqrt_controller_if.sv
// Request/result bundle between a requester and the square-root controller.
interface sqrt_controller_if #(
  parameter int unsigned W = sqrt_pkg::SQRT_W_DEF
);
  logic             Start;
  logic [W-1:0]     N;
  logic             Busy;
  logic             Done;
  logic [W/2-1:0]   Root;
  logic [W-1:0]     Rem;

  modport master (output Start, N, input Busy, Done, Root, Rem);
  modport slave  (input Start, N, output Busy, Done, Root, Rem);
endinterface

// File: rtl/sqrt_top.sv
// Integration wrapper: controller plus the odd-integer register it steers.
module sqrt_top
  import sqrt_pkg::*;
#(
  parameter int unsigned W = SQRT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sqrt_controller_if.slave bus
);

  logic [W/2:0] curr_num;
  logic         inc;
  logic         clr_odd;

  sqrt_controller #(.W(W)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .curr_num (curr_num),
    .Inc      (inc),
    .Clr_odd  (clr_odd)
  );

  // Clr_odd restores the odd register to 1 at the start of each computation.
  square_root #(.W(W)) u_odd (
    .clk      (clk),
    .rst      (rst | clr_odd),
    .Inc      (inc),
    .curr_num (curr_num)
  );

endmodule

// File: rtl/square_root.sv
// Odd-integer register: holds 1, 3, 5, ... and advances by 2 on Inc.
module square_root
  import sqrt_pkg::*;
#(
  parameter int unsigned W = SQRT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Inc,
  output logic [W/2:0] curr_num
);

  localparam int unsigned CW = W / 2 + 1;

  logic [CW-1:0] odd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odd_q <= CW'(1);
    end else if (Inc) begin
      odd_q <= odd_q + CW'(2);
    end
  end

  assign curr_num = odd_q;

endmodule

// File: rtl/sqrt_controller.sv
// Control FSM and remainder datapath for odd-number-subtraction integer sqrt.
module sqrt_controller
  import sqrt_pkg::*;
#(
  parameter int unsigned W = SQRT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sqrt_controller_if.slave     bus,
  input  logic [W/2:0]         curr_num,
  output logic                 Inc,
  output logic                 Clr_odd
);

  localparam int unsigned RW = W / 2;

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [RW-1:0] root_q, root_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          clr_q, clr_d;

  logic accept;
  logic r_ge;

  // Start is only honoured while no computation is in flight.
  assign accept = bus.Start && ((state_q == IDLE) || (state_q == DONE));
  assign r_ge   = (r_q >= W'(curr_num));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = CMP;
      CMP:     state_d = r_ge ? SUB : DONE;
      SUB:     state_d = CMP;
      DONE:    if (accept) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Inc is a Moore output so the odd register steps on the same edge as R.
  always_comb begin
    Inc = 1'b0;
    if (state_q == SUB) Inc = 1'b1;
  end

  always_comb begin
    r_d    = r_q;
    rem_d  = rem_q;
    root_d = root_q;
    done_d = done_q;
    busy_d = busy_q;
    clr_d  = 1'b0;
    if (accept) begin
      r_d    = bus.N;
      root_d = '0;
      clr_d  = 1'b1;
      done_d = 1'b0;
      busy_d = 1'b1;
    end else if ((state_q == CMP) && !r_ge) begin
      rem_d  = r_q;
      done_d = 1'b1;
      busy_d = 1'b0;
    end else if (state_q == SUB) begin
      r_d    = r_q - W'(curr_num);
      root_d = root_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      done_q <= done_d;
      busy_q <= busy_d;
      clr_q  <= clr_d;
    end
  end

  assign bus.Root = root_q;
  assign bus.Rem  = rem_q;
  assign bus.Done = done_q;
  assign bus.Busy = busy_q;
  assign Clr_odd  = clr_q;

endmodule
